flash_programmer: RTL
=====================

Name: flash_programmer

Overview:
- Flash write-side engine: takes one command per handshake and executes it on the parallel NOR flash (Intel/StrataFlash command set, 16-bit word mode).
- Commands: word program, or block erase.
- Each command is one full bus sequence: command cycles, status polling, then return to read-array mode.
- Sits beside the flash-to-RAM1 boot loader as the path that puts monitor/kernel images into flash; the host is the monitor controller or a UART loader.

Parameters:
- WE_CYCLES, 2: clk cycles FlashWE is held low per bus write (minimum 1).
- POLL_TIMEOUT, 2000000: maximum status polls before a timeout error.
- TO_W, 21: width of the poll counter (must hold POLL_TIMEOUT).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_erase  in  1  1 = block erase, 0 = word program.
- cmd_addr  in  16  word address; for erase, any address inside the block.
- cmd_data  in  16  program data (ignored for erase).
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse at the end of every command.
- error  out  1  result flag, valid from done until the next accept.
- status_reg  out  8  last flash status byte.
- FlashData  inout  16  flash data bus.
- FlashAddr  out  23  flash address, driven as {6'b0, addr, 1'b0}.
- FlashByte, FlashVpen, FlashRP  out  1 each  held at 1.
- FlashCE, FlashOE, FlashWE  out  1 each  active-low strobes.

Behaviour:
- Reset (async, rst=0):
  - FlashCE=FlashOE=FlashWE=1; FlashByte=FlashVpen=FlashRP=1; FlashAddr=0.
  - FlashData tri-stated; busy=0, done=0, error=0, status_reg=0; FSM to IDLE.
- Reset mid-operation: the strobes above deassert immediately and the bus releases. The flash's internal operation is not tracked; the host must re-issue the command.
- Accept: on the clk edge with cmd_valid&&cmd_ready:
  - latch cmd_addr/cmd_data/cmd_erase;
  - busy=1, error=0, FlashCE=0.
  - cmd_valid while busy is ignored.
- BUS_WRITE sub-sequence, used for every command word:
  - SETUP, 1 cycle: address and data driven, WE=1, OE=1.
  - PULSE, WE_CYCLES cycles: WE=0.
  - HOLD, 1 cycle: WE=1, data still driven.
  - Bus released after HOLD.
  - FlashData is driven only in SETUP/PULSE/HOLD and never while OE=0.
- State machine: IDLE -> WR1 -> WR2 -> POLL_OE -> POLL_SAMPLE -> (CLR) -> RD_ARRAY -> FINISH -> IDLE.
- WR1 (BUS_WRITE): 0x0040 for program, 0x0020 for erase.
- WR2 (BUS_WRITE): cmd_data for program, 0x00D0 for erase, at the same address.
- POLL_OE: OE=0 for 1 cycle.
- POLL_SAMPLE: sample FlashData[7:0], OE=1, poll counter +1.
  - DQ7=0 and count<POLL_TIMEOUT: back to POLL_OE.
  - DQ7=0 and count==POLL_TIMEOUT: error=1, status_reg=8'h00, go to CLR.
  - DQ7=1: status_reg=DQ[7:0]; error = DQ[5]|DQ[4]|DQ[3]|DQ[1]; go to CLR if error, else RD_ARRAY.
- CLR: BUS_WRITE 0x0050 (clear status).
- RD_ARRAY: BUS_WRITE 0x00FF so the boot loader sees array data.
- FINISH: CE=1, done=1 for one cycle, busy=0, back to IDLE.
- Back-to-back commands: a new command may be accepted the cycle after done.
- Poll counter clears on accept.
- Program latency with WE_CYCLES=2 and ready on the first poll: 1 (accept) + 4+4 (WR1, WR2) + 2 (poll) + 4 (RD_ARRAY) + 1 (FINISH) = 16 cycles from accept to done.

Optional Feature:
- Macro FLASH_VERIFY_EN.
- Defined, program commands only: after RD_ARRAY a VERIFY phase runs.
  - OE=0 for 1 cycle, then sample FlashData and set OE=1.
  - On mismatch with cmd_data: error=1 and status_reg[0]=1.
  - Adds 2 cycles to program latency.
- Undefined: no readback; status_reg[0] always reflects the flash status bit.

Test Plan:
- Program addr 0x0010, data 0xBEEF; model returns status 0x80 on first poll -> bus writes 0x0040 then 0xBEEF at FlashAddr 0x000020, then 0x00FF; done at 16 cycles; error=0; status_reg=0x80.
- Erase at cmd_addr 0x1234 -> writes 0x0020, 0x00D0 at 0x002468; model returns 0x00 for 5 polls then 0x80 -> exactly 6 POLL_OE cycles, error=0.
- Program, model status 0x90 (bit4) -> error=1, status_reg=0x90; 0x0050 issued before 0x00FF.
- POLL_TIMEOUT=16, model never ready -> 16 polls, error=1, status_reg=0x00, done pulses once.
- Reset asserted during WR2 PULSE -> FlashWE=1, CE=1 and FlashData=Z in the same timestep; busy=0. A second cmd_valid held high during a busy command is accepted only after done.
- FLASH_VERIFY_EN defined, model reads back 0xBEEE for 0xBEEF -> error=1, status_reg=0x81.

Source files
------------

// File: rtl/flash_programmer_if.sv
// Command handshake and result signals between a flash host and flash_programmer.
interface flash_programmer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_erase;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  status_reg;

  modport master (output cmd_valid, cmd_erase, cmd_addr, cmd_data,
                  input  cmd_ready, busy, done, error, status_reg);
  modport slave  (input  cmd_valid, cmd_erase, cmd_addr, cmd_data,
                  output cmd_ready, busy, done, error, status_reg);
endinterface

// File: rtl/flash_programmer.sv
// Word-program / block-erase engine for a 16-bit Intel-command-set NOR flash.
// Define FLASH_VERIFY_EN to add a readback check after every word program.
module flash_programmer #(
  parameter int WE_CYCLES    = 2,
  parameter int POLL_TIMEOUT = 2000000,
  parameter int TO_W         = 21
) (
  input  logic              clk,
  input  logic              rst,
  flash_programmer_if.slave cmd,
  inout  wire  [15:0]       FlashData,
  output logic [22:0]       FlashAddr,
  output logic              FlashByte,
  output logic              FlashVpen,
  output logic              FlashRP,
  output logic              FlashCE,
  output logic              FlashOE,
  output logic              FlashWE
);
  localparam int PW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
`ifdef FLASH_VERIFY_EN
  localparam int DQ_W = 16;
`else
  localparam int DQ_W = 8;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_WR1, S_WR2, S_POLL_OE, S_POLL_SAMPLE, S_CLR,
    S_RD_ARRAY, S_VERIFY_OE, S_VERIFY_SAMPLE, S_FINISH
  } state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

  state_t            r_state, w_state_nxt;
  phase_t            r_phase, w_phase_nxt;
  logic [PW-1:0]     r_pcnt, w_pcnt_nxt;
  logic [TO_W-1:0]   r_poll_cnt, w_poll_nxt, w_poll_inc;
  logic              r_erase, w_erase_nxt;
  logic [15:0]       r_cmd_data, w_data_nxt;
  logic [22:0]       r_flash_addr, w_addr_nxt;
  logic [DQ_W-1:0]   r_dq, w_dq_nxt;
  logic              r_ready, r_busy, r_done, r_error, w_error_nxt;
  logic [7:0]        r_status, w_status_nxt;
  logic              r_ce, r_oe, r_we, r_drive;
  logic              w_ce_nxt, w_oe_nxt, w_we_nxt, w_wr_nxt;
  logic [15:0]       r_dout, w_dout_nxt;
  logic              w_accept, w_in_wr, w_wr_done;

  assign w_accept    = (r_state == S_IDLE) && cmd.cmd_valid && r_ready;
  assign w_erase_nxt = w_accept ? cmd.cmd_erase : r_erase;
  assign w_data_nxt  = w_accept ? cmd.cmd_data : r_cmd_data;
  assign w_addr_nxt  = w_accept ? {6'b000000, cmd.cmd_addr, 1'b0} : r_flash_addr;
  assign w_in_wr     = (r_state == S_WR1) || (r_state == S_WR2) ||
                       (r_state == S_CLR) || (r_state == S_RD_ARRAY);
  assign w_poll_inc  = r_poll_cnt + TO_W'(1);
  assign w_dq_nxt    = ((r_state == S_POLL_OE) || (r_state == S_VERIFY_OE)) ?
                       FlashData[DQ_W-1:0] : r_dq;

  // Next state, bus-write phase stepping and result flags
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = PH_SETUP;
    w_pcnt_nxt   = r_pcnt;
    w_poll_nxt   = r_poll_cnt;
    w_error_nxt  = r_error;
    w_status_nxt = r_status;
    w_wr_done    = 1'b0;
    if (w_in_wr) begin
      case (r_phase)
        PH_SETUP: begin
          w_phase_nxt = PH_PULSE;
          w_pcnt_nxt  = '0;
        end
        PH_PULSE: begin
          if (r_pcnt == PW'(WE_CYCLES - 1)) begin
            w_phase_nxt = PH_HOLD;
          end else begin
            w_phase_nxt = PH_PULSE;
            w_pcnt_nxt  = r_pcnt + PW'(1);
          end
        end
        PH_HOLD: w_wr_done = 1'b1;
        default: w_phase_nxt = PH_SETUP;
      endcase
    end else begin
      w_phase_nxt = PH_SETUP;
    end
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_WR1;
          w_poll_nxt  = '0;
          w_error_nxt = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR1:     w_state_nxt = w_wr_done ? S_WR2 : S_WR1;
      S_WR2:     w_state_nxt = w_wr_done ? S_POLL_OE : S_WR2;
      S_POLL_OE: w_state_nxt = S_POLL_SAMPLE;
      S_POLL_SAMPLE: begin
        w_poll_nxt = w_poll_inc;
        if (r_dq[7]) begin
          // Only the erase/program/VPP/lock fault bits count as failures.
          w_status_nxt = r_dq[7:0];
          w_error_nxt  = r_dq[5] | r_dq[4] | r_dq[3] | r_dq[1];
          w_state_nxt  = w_error_nxt ? S_CLR : S_RD_ARRAY;
        end else if (w_poll_inc >= TO_W'(POLL_TIMEOUT)) begin
          w_status_nxt = 8'h00;
          w_error_nxt  = 1'b1;
          w_state_nxt  = S_CLR;
        end else begin
          w_state_nxt = S_POLL_OE;
        end
      end
      S_CLR: w_state_nxt = w_wr_done ? S_RD_ARRAY : S_CLR;
`ifdef FLASH_VERIFY_EN
      S_RD_ARRAY: w_state_nxt = !w_wr_done ? S_RD_ARRAY : (r_erase ? S_FINISH : S_VERIFY_OE);
      S_VERIFY_OE: w_state_nxt = S_VERIFY_SAMPLE;
      S_VERIFY_SAMPLE: begin
        w_state_nxt = S_FINISH;
        if (r_dq != r_cmd_data) begin
          w_error_nxt  = 1'b1;
          w_status_nxt = r_status | 8'h01;
        end else begin
          w_error_nxt = r_error;
        end
      end
`else
      S_RD_ARRAY: w_state_nxt = w_wr_done ? S_FINISH : S_RD_ARRAY;
`endif
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Bus strobes and write word for the state being entered
  always_comb begin
    w_wr_nxt = (w_state_nxt == S_WR1) || (w_state_nxt == S_WR2) ||
               (w_state_nxt == S_CLR) || (w_state_nxt == S_RD_ARRAY);
    w_we_nxt = !(w_wr_nxt && (w_phase_nxt == PH_PULSE));
    w_oe_nxt = !((w_state_nxt == S_POLL_OE) || (w_state_nxt == S_VERIFY_OE));
    w_ce_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_FINISH);
    case (w_state_nxt)
      S_WR1:      w_dout_nxt = w_erase_nxt ? 16'h0020 : 16'h0040;
      S_WR2:      w_dout_nxt = w_erase_nxt ? 16'h00D0 : w_data_nxt;
      S_CLR:      w_dout_nxt = 16'h0050;
      S_RD_ARRAY: w_dout_nxt = 16'h00FF;
      default:    w_dout_nxt = 16'h0000;
    endcase
  end

  // State and registered outputs; reset releases the bus immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_phase      <= PH_SETUP;
      r_pcnt       <= '0;
      r_poll_cnt   <= '0;
      r_erase      <= 1'b0;
      r_cmd_data   <= 16'h0000;
      r_flash_addr <= 23'h000000;
      r_dq         <= '0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_status     <= 8'h00;
      r_ce         <= 1'b1;
      r_oe         <= 1'b1;
      r_we         <= 1'b1;
      r_drive      <= 1'b0;
      r_dout       <= 16'h0000;
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_pcnt       <= w_pcnt_nxt;
      r_poll_cnt   <= w_poll_nxt;
      r_erase      <= w_erase_nxt;
      r_cmd_data   <= w_data_nxt;
      r_flash_addr <= w_addr_nxt;
      r_dq         <= w_dq_nxt;
      r_ready      <= (w_state_nxt == S_IDLE);
      r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_FINISH);
      r_done       <= (w_state_nxt == S_FINISH);
      r_error      <= w_error_nxt;
      r_status     <= w_status_nxt;
      r_ce         <= w_ce_nxt;
      r_oe         <= w_oe_nxt;
      r_we         <= w_we_nxt;
      r_drive      <= w_wr_nxt;
      r_dout       <= w_dout_nxt;
    end
  end

  assign FlashData      = r_drive ? r_dout : 16'hzzzz;
  assign FlashAddr      = r_flash_addr;
  assign FlashCE        = r_ce;
  assign FlashOE        = r_oe;
  assign FlashWE        = r_we;
  assign FlashByte      = 1'b1;
  assign FlashVpen      = 1'b1;
  assign FlashRP        = 1'b1;
  assign cmd.cmd_ready  = r_ready;
  assign cmd.busy       = r_busy;
  assign cmd.done       = r_done;
  assign cmd.error      = r_error;
  assign cmd.status_reg = r_status;
endmodule
